game_collision_manager: RTL

- Parametrised successor to the single-gold, single-alien collision logic: N gold bags, M aliens, per-frame sticky collision accumulation, frame-synchronous one-clock event pulses, a score accumulator, and a player lives/invulnerability FSM.
- Sits between the object drawers (terrain, player, shot, aliens, gold) and the game objects and score display.
- Consumes per-pixel drawing requests during the scan.
- Pixel-accurate terrain and shot collisions stay combinational; all game events are registered and issued once per frame.

---
 rtl/game_collision_manager_if.sv | 46 ++++
 rtl/game_collision_manager.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/game_collision_manager_if.sv
// Drawer-side bus for the collision manager: per-pixel drawing requests in,
// frame events, lives, status and score out.
interface game_collision_manager_if #(
  parameter int NUM_GOLD     = 4,
  parameter int NUM_ALIEN    = 4,
  parameter int GOLD_STATE_W = 4,
  parameter int PLAYER_LIVES = 3,
  parameter int SCORE_W      = 16
);
  localparam int LIVES_W = $clog2(PLAYER_LIVES + 1);

  logic                             startOfFrame;
  logic                             drawing_request_terrain;
  logic                             empty_square_terrain;
  logic                             drawing_request_player;
  logic                             player_awake;
  logic                             shot_dr;
  logic [NUM_ALIEN-1:0]             alien_dr;
  logic [NUM_GOLD-1:0]              gold_dr;
  logic [NUM_GOLD*GOLD_STATE_W-1:0] gold_state;

  logic                             collision_player_terrain;
  logic                             colision_fire;
  logic [NUM_GOLD-1:0]              collision_gold;
  logic [NUM_GOLD-1:0]              player_eat_gold;
  logic [NUM_ALIEN-1:0]             alien_died;
  logic                             player_died;
  logic [LIVES_W-1:0]               lives;
  logic                             invulnerable;
  logic                             game_over;
  logic [SCORE_W-1:0]               score;

  modport master (
    output startOfFrame, drawing_request_terrain, empty_square_terrain,
           drawing_request_player, player_awake, shot_dr, alien_dr, gold_dr, gold_state,
    input  collision_player_terrain, colision_fire, collision_gold, player_eat_gold,
           alien_died, player_died, lives, invulnerable, game_over, score
  );

  modport slave (
    input  startOfFrame, drawing_request_terrain, empty_square_terrain,
           drawing_request_player, player_awake, shot_dr, alien_dr, gold_dr, gold_state,
    output collision_player_terrain, colision_fire, collision_gold, player_eat_gold,
           alien_died, player_died, lives, invulnerable, game_over, score
  );
endinterface

// File: rtl/game_collision_manager.sv
// Collision manager: combinational pixel collisions, per-frame sticky hit accumulation,
// one-clock frame events, saturating score and the player lives/invulnerability FSM.
module game_collision_manager #(
  parameter int                      NUM_GOLD      = 4,
  parameter int                      NUM_ALIEN     = 4,
  parameter int                      GOLD_STATE_W  = 4,
  parameter logic [GOLD_STATE_W-1:0] GOLD_FALLING  = GOLD_STATE_W'(1),
  parameter logic [GOLD_STATE_W-1:0] GOLD_BROKEN   = GOLD_STATE_W'(2),
  parameter int                      PLAYER_LIVES  = 3,
  parameter int                      INVULN_FRAMES = 60,
  parameter int                      GOLD_POINTS   = 500,
  parameter int                      ALIEN_POINTS  = 250,
  parameter int                      SCORE_W       = 16
) (
  input logic                     clk,
  input logic                     resetN,
  game_collision_manager_if.slave io_bus
);
  localparam int LIVES_W = $clog2(PLAYER_LIVES + 1);
  localparam int CNT_W   = $clog2(INVULN_FRAMES + 1);
  localparam int SUM_W   = SCORE_W + 4;

  typedef enum logic [1:0] {ST_PLAY, ST_INVULN, ST_GAME_OVER} state_t;

  function automatic logic [SUM_W-1:0] popcount_gold(input logic [NUM_GOLD-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_GOLD; i++) c = c + SUM_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SUM_W-1:0] popcount_alien(input logic [NUM_ALIEN-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int j = 0; j < NUM_ALIEN; j++) c = c + SUM_W'(v[j]);
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SUM_W-1:0] s);
    if (|s[SUM_W-1:SCORE_W]) return '1;
    return s[SCORE_W-1:0];
  endfunction

  state_t               r_state, w_state_nxt;
  logic [LIVES_W-1:0]   r_lives, w_lives_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0]   r_score;

  logic [NUM_GOLD-1:0]  r_acc_gh, r_acc_ge, r_collision_gold, r_player_eat_gold;
  logic [NUM_ALIEN-1:0] r_acc_ak, r_alien_died;
  logic                 r_acc_pk, r_player_died;

  logic [NUM_GOLD-1:0]  w_gold_falling, w_gold_broken, w_gh, w_ge;
  logic [NUM_ALIEN-1:0] w_ak;
  logic                 w_player, w_any_alien, w_any_falling, w_pk, w_pk_frame;
  logic                 w_sof, w_live, w_invulnerable, w_game_over;
  logic [SUM_W-1:0]     w_score_sum;

  always_comb begin
    w_gold_falling = '0;
    w_gold_broken  = '0;
    for (int i = 0; i < NUM_GOLD; i++) begin
      w_gold_falling[i] = io_bus.gold_dr[i] &
                          (io_bus.gold_state[i*GOLD_STATE_W +: GOLD_STATE_W] == GOLD_FALLING);
      w_gold_broken[i]  = (io_bus.gold_state[i*GOLD_STATE_W +: GOLD_STATE_W] == GOLD_BROKEN);
    end
  end

  assign w_sof         = io_bus.startOfFrame;
  assign w_player      = io_bus.drawing_request_player;
  assign w_any_alien   = |io_bus.alien_dr;
  assign w_any_falling = |w_gold_falling;
  assign w_gh          = io_bus.gold_dr & {NUM_GOLD{w_player | w_any_alien}};
  assign w_ge          = io_bus.gold_dr & w_gold_broken & {NUM_GOLD{w_player}};
  assign w_ak          = io_bus.alien_dr & {NUM_ALIEN{io_bus.shot_dr | w_any_falling}};
  assign w_pk          = w_player & io_bus.player_awake & (w_any_alien | w_any_falling);
  assign w_pk_frame    = r_acc_pk | w_pk;
  assign w_live        = (r_state != ST_GAME_OVER);

  assign io_bus.collision_player_terrain = io_bus.drawing_request_terrain & w_player;
  assign io_bus.colision_fire = io_bus.shot_dr &
    ((io_bus.drawing_request_terrain & ~io_bus.empty_square_terrain) | w_any_alien);

  // Accumulate during the frame; at the boundary hand the frame's hits to the event regs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc_gh          <= '0;
      r_acc_ge          <= '0;
      r_acc_ak          <= '0;
      r_acc_pk          <= 1'b0;
      r_collision_gold  <= '0;
      r_player_eat_gold <= '0;
      r_alien_died      <= '0;
      r_player_died     <= 1'b0;
    end else if (w_sof) begin
      r_acc_gh          <= '0;
      r_acc_ge          <= '0;
      r_acc_ak          <= '0;
      r_acc_pk          <= 1'b0;
      r_collision_gold  <= w_live ? (r_acc_gh | w_gh) : '0;
      r_player_eat_gold <= w_live ? (r_acc_ge | w_ge) : '0;
      r_alien_died      <= w_live ? (r_acc_ak | w_ak) : '0;
      r_player_died     <= (r_state == ST_PLAY) & w_pk_frame;
    end else begin
      r_acc_gh          <= r_acc_gh | w_gh;
      r_acc_ge          <= r_acc_ge | w_ge;
      r_acc_ak          <= r_acc_ak | w_ak;
      r_acc_pk          <= w_pk_frame;
      r_collision_gold  <= '0;
      r_player_eat_gold <= '0;
      r_alien_died      <= '0;
      r_player_died     <= 1'b0;
    end
  end

  // Event regs are zero outside the post-boundary cycle, so adding them every cycle is safe
  assign w_score_sum = SUM_W'(r_score)
                     + SUM_W'(GOLD_POINTS)  * popcount_gold(r_player_eat_gold)
                     + SUM_W'(ALIEN_POINTS) * popcount_alien(r_alien_died);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_score <= '0;
    else         r_score <= sat_score(w_score_sum);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_PLAY;
      r_lives <= LIVES_W'(PLAYER_LIVES);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lives <= w_lives_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_PLAY: begin
        if (w_sof && w_pk_frame) begin
          if (r_lives > LIVES_W'(1)) begin
            w_lives_nxt = r_lives - LIVES_W'(1);
            w_cnt_nxt   = CNT_W'(INVULN_FRAMES);
            w_state_nxt = ST_INVULN;
          end else begin
            w_lives_nxt = '0;
            w_state_nxt = ST_GAME_OVER;
          end
        end
      end
      ST_INVULN: begin
        if (w_sof) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PLAY;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_invulnerable = 1'b0;
    w_game_over    = 1'b0;
    case (r_state)
      ST_INVULN:    w_invulnerable = 1'b1;
      ST_GAME_OVER: w_game_over    = 1'b1;
      default: ;
    endcase
  end

  assign io_bus.collision_gold  = r_collision_gold;
  assign io_bus.player_eat_gold = r_player_eat_gold;
  assign io_bus.alien_died      = r_alien_died;
  assign io_bus.player_died     = r_player_died;
  assign io_bus.lives           = r_lives;
  assign io_bus.invulnerable    = w_invulnerable;
  assign io_bus.game_over       = w_game_over;
  assign io_bus.score           = r_score;
endmodule
